// File: rtl/control_unit_pkg.sv
// Shared constants and types for the control_unit slice.
// Status flags are built only when CONTROL_UNIT_FLAGS_EN is defined.
package control_unit_pkg;

  localparam int CU_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu16.sv
// Combinational datapath: ADD/SUB/NOT/AND with carry and signed overflow.
// Used by control_unit, which owns all registers.
module alu16
  import control_unit_pkg::*;
#(
  parameter int WIDTH = CU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // The extra top bit is carry-out for ADD and borrow (A < B) for SUB.
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = w_sum[WIDTH-1:0];
        carry    = w_sum[WIDTH];
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result   = w_diff[WIDTH-1:0];
        carry    = w_diff[WIDTH];
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_NOT: result = ~A;
      OP_AND: result = A & B;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// IDLE/EXEC/DONE sequencer around alu16; latches operands on accept, registers result on EXEC.
// Define CONTROL_UNIT_FLAGS_EN to build the zero/negative/carry/overflow flag registers.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WIDTH = CU_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output state_t           o_state
);

  // Handshake: start is a request sampled only in IDLE; done is a one-cycle
  // completion strobe; busy marks the window in which start is ignored.

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  alu16 #(.WIDTH(WIDTH)) u_alu (
    .A        (r_a),
    .B        (r_b),
    .op       (r_op),
    .result   (w_alu_result),
    .carry    (w_alu_carry),
    .overflow (w_alu_ovf)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_EXEC) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
  end

  assign o_state = r_state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_op <= opCode;
      r_a  <= inputA;
      r_b  <= inputB;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)                   r_result <= '0;
    else if (r_state == ST_EXEC) r_result <= w_alu_result;
  end

  assign result = r_result;

`ifdef CONTROL_UNIT_FLAGS_EN
  logic r_zero;
  logic r_negative;
  logic r_carry;
  logic r_overflow;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_zero     <= (w_alu_result == '0);
      r_negative <= w_alu_result[WIDTH-1];
      r_carry    <= w_alu_carry;
      r_overflow <= w_alu_ovf;
    end
  end

  assign zero     = r_zero;
  assign negative = r_negative;
  assign carry    = r_carry;
  assign overflow = r_overflow;
`else
  // ALU status is still computed but deliberately dropped in this build.
  logic w_unused_flags;
  assign w_unused_flags = w_alu_carry ^ w_alu_ovf;

  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: timing, arithmetic corners, back-to-back starts, abort by clear.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int W = 16;
`ifdef CONTROL_UNIT_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [1:0]   opCode;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  state_t       o_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W+3:0] exp_q[$];
  int           done_cyc[$];

  control_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .opCode   (opCode),
    .inputA   (inputA),
    .inputB   (inputB),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .o_state  (o_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word layout: {result, zero, negative, carry, overflow}.
  function automatic logic [W+3:0] mk(input logic [W-1:0] res, input logic z, input logic n,
                                      input logic c, input logic v);
    return {res, {z, n, c, v} & FLAG_MASK};
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ua, ub, sa, sb, full, sres;
    logic [W-1:0] res;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; res = '0;
    case (op)
      2'b00: begin
        full = ua + ub; res = full[W-1:0]; c = (full > 65535);
        sres = sa + sb; v = (sres > 32767) || (sres < -32768);
      end
      2'b01: begin
        full = ua - ub; res = full[W-1:0]; c = (ua < ub);
        sres = sa - sb; v = (sres > 32767) || (sres < -32768);
      end
      2'b10: res = ~a;
      default: res = a & b;
    endcase
    return mk(res, res == 0, res[W-1], c, v);
  endfunction

  function automatic logic [W+3:0] observed();
    return {result, zero, negative, carry, overflow};
  endfunction

  // Scoreboard: every completion pops the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else chk("sb_result_flags", observed(), exp_q.pop_front());
    end
  end

  // Called with the clock low; returns at the negedge after the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] exp);
    opCode = op; inputA = a; inputB = b; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock);
    start = 1'b0;
    inputA = ~a; inputB = b ^ 16'h5A5A; opCode = ~op;
    chk("exec_busy", busy, 1); chk("exec_done", done, 0); chk("exec_state", o_state, ST_EXEC);
    @(negedge clock);
    chk("done_pulse", done, 1); chk("done_busy", busy, 1);
    @(negedge clock);
    chk("done_drop", done, 0); chk("idle_busy", busy, 0);
    chk("result_hold", observed(), exp);
  endtask

  logic [1:0]   b2b_op[4];
  logic [W-1:0] b2b_a[4];
  logic [W-1:0] b2b_b[4];
  logic [W+3:0] discard;

  initial begin
    clear = 1'b1; start = 1'b0; opCode = '0; inputA = '0; inputB = '0;
    #1;
    chk("rst_result", result, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_flags", {zero, negative, carry, overflow}, 0);
    chk("rst_state", o_state, ST_IDLE);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    do_op(OP_ADD, 16'h0325, 16'h012E, mk(16'h0453, 0, 0, 0, 0));
    do_op(OP_SUB, 16'h0325, 16'h012E, mk(16'h01F7, 0, 0, 0, 0));
    do_op(OP_SUB, 16'h012E, 16'h012E, mk(16'h0000, 1, 0, 0, 0));
    do_op(OP_NOT, 16'h012E, 16'h012E, mk(16'hFED1, 0, 1, 0, 0));
    do_op(OP_AND, 16'h0325, 16'h012E, mk(16'h0124, 0, 0, 0, 0));
    do_op(OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0, 1));
    do_op(OP_ADD, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 0, 1, 0));
    do_op(OP_SUB, 16'h0000, 16'h0001, mk(16'hFFFF, 0, 1, 1, 0));
    do_op(OP_SUB, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 0, 0, 1));
    do_op(OP_ADD, 16'h8000, 16'h8000, mk(16'h0000, 1, 0, 1, 1));

    for (int i = 0; i < 6; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      do_op(rop, ra, rb, model(rop, ra, rb));
    end

    // start held high for four operations; operands scrambled during EXEC
    for (int k = 0; k < 4; k++) begin
      b2b_op[k] = 2'($urandom_range(0, 3));
      b2b_a[k]  = 16'($urandom_range(1, 65535));
      b2b_b[k]  = 16'($urandom_range(1, 65535));
    end
    b2b_op[3] = OP_ADD; b2b_a[3] = 16'h1234; b2b_b[3] = 16'h0101;
    done_cyc.delete();
    opCode = b2b_op[0]; inputA = b2b_a[0]; inputB = b2b_b[0]; start = 1'b1;
    exp_q.push_back(model(b2b_op[0], b2b_a[0], b2b_b[0]));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      opCode = 2'($urandom_range(0, 3));
      inputA = 16'($urandom_range(0, 65535));
      inputB = 16'($urandom_range(0, 65535));
      @(negedge clock);
      if (k < 3) begin
        opCode = b2b_op[k+1]; inputA = b2b_a[k+1]; inputB = b2b_b[k+1];
        exp_q.push_back(model(b2b_op[k+1], b2b_a[k+1], b2b_b[k+1]));
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    chk("b2b_done_count", done_cyc.size(), 4);
    for (int i = 1; i < done_cyc.size(); i++)
      chk("b2b_spacing", done_cyc[i] - done_cyc[i-1], 3);
    chk("b2b_last_hold", observed(), mk(16'h1335, 0, 0, 0, 0));

    // clear in EXEC aborts: outputs zero at once, no completion
    opCode = OP_ADD; inputA = 16'h4000; inputB = 16'h4000; start = 1'b1;
    exp_q.push_back(model(OP_ADD, 16'h4000, 16'h4000));
    @(negedge clock);
    start = 1'b0;
    chk("abort_in_exec", o_state, ST_EXEC);
    clear = 1'b1;
    #1;
    discard = exp_q.pop_back();
    chk("clr_result", result, 0);
    chk("clr_busy_done", {busy, done}, 0);
    chk("clr_flags", {zero, negative, carry, overflow}, 0);
    chk("clr_state", o_state, ST_IDLE);
    @(negedge clock);
    @(negedge clock);
    chk("clr_no_done", done, 0);
    chk("clr_result_held", result, 0);
    clear = 1'b0;
    do_op(OP_AND, 16'hF0F0, 16'hFF00, mk(16'hF000, 0, 1, 0, 0));

    repeat (3) @(negedge clock);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
